// File: rtl/l2_amba_burst.sv
// L2-to-AXI4 master bridge: moves one cache line as an INCR burst (or one uncached beat)
// over a narrower AXI data bus, with one transaction outstanding and a handshake watchdog.
module l2_amba_burst #(
   parameter int LINE_BITS          = 256,
   parameter int BUS_BITS           = 64,
   parameter int ADDR_BITS          = 48,
   parameter int TIMEOUT            = 1023,
   parameter int REQ_MEM_TYPE_BITS  = 2,
   parameter int REQ_MEM_TYPE_CACHED = 0,
   parameter int REQ_MEM_TYPE_WRITE = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic [REQ_MEM_TYPE_BITS-1:0] i_req_type,
   input  logic [2:0]                   i_req_size,
   input  logic [2:0]                   i_req_prot,
   input  logic [ADDR_BITS-1:0]         i_req_addr,
   input  logic [LINE_BITS/8-1:0]       i_req_strob,
   input  logic [LINE_BITS-1:0]         i_req_data,
   output logic                         o_resp_valid,
   output logic [LINE_BITS-1:0]         o_resp_data,
   output logic [1:0]                   o_resp_err,
   output logic                         o_ar_valid,
   input  logic                         i_ar_ready,
   output logic                         o_aw_valid,
   input  logic                         i_aw_ready,
   output logic [ADDR_BITS+14:0]        o_ax_bits,
   output logic                         o_w_valid,
   input  logic                         i_w_ready,
   output logic [BUS_BITS-1:0]          o_w_data,
   output logic [BUS_BITS/8-1:0]        o_w_strb,
   output logic                         o_w_last,
   input  logic                         i_r_valid,
   input  logic [BUS_BITS-1:0]          i_r_data,
   input  logic [1:0]                   i_r_resp,
   input  logic                         i_r_last,
   input  logic                         i_b_valid,
   input  logic [1:0]                   i_b_resp
);

   localparam int BEATS     = LINE_BITS / BUS_BITS;
   localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int STRB_BITS = BUS_BITS / 8;
   localparam int BUS_OFF   = $clog2(BUS_BITS / 8);
   localparam int WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_RD, S_AW, S_WR, S_WACK, S_RESP
   } state_t;

   state_t                   state;
   logic                     req_cached;
   logic [ADDR_BITS-1:0]     req_addr;
   logic [7:0]               req_len;
   logic [LINE_BITS-1:0]     line_buf;
   logic [LINE_BITS/8-1:0]   strob_buf;
   logic [CNT_W-1:0]         cnt;
   logic [7:0]               beat_idx;
   logic [WD_W-1:0]          wdog;
   logic [1:0]               err;

   logic                     acc_write;
   logic                     acc_cached;
   logic [ADDR_BITS-1:0]     acc_addr;
   logic [2:0]               acc_size;
   logic [7:0]               acc_len;
   logic [CNT_W-1:0]         start_slot;
   logic [CNT_W-1:0]         cnt_next;
   logic                     busy;
   logic                     any_hs;
   logic                     wdog_expire;
   logic                     unused_bits;

   assign unused_bits = &{1'b0, i_r_resp[0], i_b_resp[0]};

   assign acc_write  = i_req_type[REQ_MEM_TYPE_WRITE];
   assign acc_cached = i_req_type[REQ_MEM_TYPE_CACHED];
   assign acc_addr   = acc_cached ? (i_req_addr & ~ADDR_BITS'(LINE_BITS / 8 - 1)) : i_req_addr;
   assign acc_size   = acc_cached ? 3'(BUS_OFF) : i_req_size;
   assign acc_len    = acc_cached ? 8'(BEATS - 1) : 8'd0;

   // Uncached beats land in the line slot their address selects; bursts always start at slot 0.
   always_comb begin
      start_slot = '0;
      if (!req_cached && BEATS > 1)
         start_slot = CNT_W'(req_addr >> BUS_OFF);
   end

   assign cnt_next = (BEATS > 1) ? cnt + 1'b1 : '0;

   assign busy   = (state == S_AR) || (state == S_RD) || (state == S_AW) ||
                   (state == S_WR) || (state == S_WACK);
   assign any_hs = (o_ar_valid && i_ar_ready) || (o_aw_valid && i_aw_ready) ||
                   (o_w_valid && i_w_ready) || (state == S_RD && i_r_valid) ||
                   (state == S_WACK && i_b_valid);
   assign wdog_expire = (TIMEOUT > 0) && busy && !any_hs && (wdog == WD_W'(TIMEOUT - 1));

   assign o_w_data    = line_buf[int'(cnt)*BUS_BITS +: BUS_BITS];
   assign o_w_strb    = strob_buf[int'(cnt)*STRB_BITS +: STRB_BITS];
   assign o_w_last    = o_w_valid && (beat_idx == req_len);
   assign o_resp_data = line_buf;
   assign o_resp_err  = err;

   // The line buffer doubles as write-data store and read reassembly buffer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_IDLE;
         o_req_ready  <= 1'b1;
         o_ar_valid   <= 1'b0;
         o_aw_valid   <= 1'b0;
         o_w_valid    <= 1'b0;
         o_resp_valid <= 1'b0;
         o_ax_bits    <= '0;
         req_cached   <= 1'b0;
         req_addr     <= '0;
         req_len      <= '0;
         cnt          <= '0;
         beat_idx     <= '0;
         wdog         <= '0;
         err          <= '0;
      end else begin
         if (busy)
            wdog <= any_hs ? '0 : wdog + 1'b1;

         case (state)
            S_IDLE: begin
               if (i_req_valid) begin
                  o_req_ready <= 1'b0;
                  req_cached  <= acc_cached;
                  req_addr    <= i_req_addr;
                  req_len     <= acc_len;
                  line_buf    <= i_req_data;
                  strob_buf   <= i_req_strob;
                  o_ax_bits   <= {i_req_prot, acc_cached, acc_size, acc_len, acc_addr};
                  err         <= '0;
                  wdog        <= '0;
                  if (acc_write) begin
                     state      <= S_AW;
                     o_aw_valid <= 1'b1;
                  end else begin
                     state      <= S_AR;
                     o_ar_valid <= 1'b1;
                  end
               end
            end

            S_AR: begin
               if (i_ar_ready) begin
                  o_ar_valid <= 1'b0;
                  cnt        <= start_slot;
                  state      <= S_RD;
               end else if (wdog_expire) begin
                  o_ar_valid   <= 1'b0;
                  err[0]       <= 1'b1;
                  o_resp_valid <= 1'b1;
                  state        <= S_RESP;
               end
            end

            // The slave's r_last decides when the burst ends, even if it disagrees with len.
            S_RD: begin
               if (i_r_valid) begin
                  line_buf[int'(cnt)*BUS_BITS +: BUS_BITS] <= i_r_data;
                  err[0] <= err[0] | i_r_resp[1];
                  cnt    <= cnt_next;
                  if (i_r_last) begin
                     o_resp_valid <= 1'b1;
                     state        <= S_RESP;
                  end
               end else if (wdog_expire) begin
                  err[0]       <= 1'b1;
                  o_resp_valid <= 1'b1;
                  state        <= S_RESP;
               end
            end

            S_AW: begin
               if (i_aw_ready) begin
                  o_aw_valid <= 1'b0;
                  o_w_valid  <= 1'b1;
                  cnt        <= start_slot;
                  beat_idx   <= '0;
                  state      <= S_WR;
               end else if (wdog_expire) begin
                  o_aw_valid   <= 1'b0;
                  err[1]       <= 1'b1;
                  o_resp_valid <= 1'b1;
                  state        <= S_RESP;
               end
            end

            S_WR: begin
               if (i_w_ready) begin
                  if (beat_idx == req_len) begin
                     o_w_valid <= 1'b0;
                     state     <= S_WACK;
                  end else begin
                     cnt      <= cnt_next;
                     beat_idx <= beat_idx + 8'd1;
                  end
               end else if (wdog_expire) begin
                  o_w_valid    <= 1'b0;
                  err[1]       <= 1'b1;
                  o_resp_valid <= 1'b1;
                  state        <= S_RESP;
               end
            end

            S_WACK: begin
               if (i_b_valid) begin
                  err[1]       <= i_b_resp[1];
                  o_resp_valid <= 1'b1;
                  state        <= S_RESP;
               end else if (wdog_expire) begin
                  err[1]       <= 1'b1;
                  o_resp_valid <= 1'b1;
                  state        <= S_RESP;
               end
            end

            S_RESP: begin
               o_resp_valid <= 1'b0;
               o_req_ready  <= 1'b1;
               state        <= S_IDLE;
            end

            default: begin
               state       <= S_IDLE;
               o_req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_amba_burst.sv
// Scoreboard bench for l2_amba_burst: directed transactions push expected AX, W and
// response records; a negedge monitor pops and compares them as the bridge presents them.
module tb_l2_amba_burst;

   localparam int LINE_BITS = 256;
   localparam int BUS_BITS  = 64;
   localparam int ADDR_BITS = 48;
   localparam int T_CACHED  = 0;
   localparam int T_WRITE   = 1;

   logic                   i_clk = 1'b0;
   logic                   i_rst = 1'b1;
   logic                   i_req_valid = 1'b0;
   logic                   o_req_ready;
   logic [1:0]             i_req_type = '0;
   logic [2:0]             i_req_size = '0;
   logic [2:0]             i_req_prot = '0;
   logic [ADDR_BITS-1:0]   i_req_addr = '0;
   logic [31:0]            i_req_strob = '0;
   logic [LINE_BITS-1:0]   i_req_data = '0;
   logic                   o_resp_valid;
   logic [LINE_BITS-1:0]   o_resp_data;
   logic [1:0]             o_resp_err;
   logic                   o_ar_valid;
   logic                   i_ar_ready = 1'b0;
   logic                   o_aw_valid;
   logic                   i_aw_ready = 1'b0;
   logic [ADDR_BITS+14:0]  o_ax_bits;
   logic                   o_w_valid;
   logic                   i_w_ready = 1'b0;
   logic [BUS_BITS-1:0]    o_w_data;
   logic [7:0]             o_w_strb;
   logic                   o_w_last;
   logic                   i_r_valid = 1'b0;
   logic [BUS_BITS-1:0]    i_r_data = '0;
   logic [1:0]             i_r_resp = '0;
   logic                   i_r_last = 1'b0;
   logic                   i_b_valid = 1'b0;
   logic [1:0]             i_b_resp = '0;

   l2_amba_burst #(
      .LINE_BITS(LINE_BITS), .BUS_BITS(BUS_BITS), .ADDR_BITS(ADDR_BITS), .TIMEOUT(16),
      .REQ_MEM_TYPE_BITS(2), .REQ_MEM_TYPE_CACHED(T_CACHED), .REQ_MEM_TYPE_WRITE(T_WRITE)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_type(i_req_type),
      .i_req_size(i_req_size), .i_req_prot(i_req_prot), .i_req_addr(i_req_addr),
      .i_req_strob(i_req_strob), .i_req_data(i_req_data),
      .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .o_resp_err(o_resp_err),
      .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready),
      .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_ax_bits(o_ax_bits),
      .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
      .o_w_strb(o_w_strb), .o_w_last(o_w_last),
      .i_r_valid(i_r_valid), .i_r_data(i_r_data), .i_r_resp(i_r_resp), .i_r_last(i_r_last),
      .i_b_valid(i_b_valid), .i_b_resp(i_b_resp)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [LINE_BITS-1:0] line;
      logic [1:0]           err;
      bit                   check_data;
   } resp_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } wbeat_t;

   resp_t                 exp_resp[$];
   logic [ADDR_BITS+14:0] exp_ax[$];
   wbeat_t                exp_w[$];
   resp_t                 mon_r;
   wbeat_t                mon_w;

   int vectors = 0;
   int miscompares = 0;

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   task automatic boundFail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: event not seen within cycle budget, want it seen", name);
   endtask

   // Monitor: everything the bridge presents is compared against what stimulus queued.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (o_resp_valid) begin
            if (exp_resp.size() == 0) boundFail("unexpected_resp");
            else begin
               mon_r = exp_resp.pop_front();
               checkOutput("resp_err", 256'(o_resp_err), 256'(mon_r.err));
               if (mon_r.check_data) checkOutput("resp_data", o_resp_data, mon_r.line);
            end
         end
         if ((o_ar_valid && i_ar_ready) || (o_aw_valid && i_aw_ready)) begin
            if (exp_ax.size() == 0) boundFail("unexpected_ax");
            else checkOutput("ax_bits", 256'(o_ax_bits), 256'(exp_ax.pop_front()));
         end
         if (o_w_valid && i_w_ready) begin
            if (exp_w.size() == 0) boundFail("unexpected_w");
            else begin
               mon_w = exp_w.pop_front();
               checkOutput("w_beat", 256'({o_w_data, o_w_strb, o_w_last}),
                           256'({mon_w.data, mon_w.strb, mon_w.last}));
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic write, input logic cached, input logic [2:0] size,
                                input logic [2:0] prot, input logic [ADDR_BITS-1:0] addr,
                                input logic [LINE_BITS-1:0] data, input logic [31:0] strob);
      logic [1:0] t;
      int n = 0;
      while (!o_req_ready && n < 40) begin
         tick();
         n++;
      end
      if (!o_req_ready) boundFail("req_ready_wait");
      t = '0;
      t[T_WRITE]  = write;
      t[T_CACHED] = cached;
      i_req_type  = t;
      i_req_size  = size;
      i_req_prot  = prot;
      i_req_addr  = addr;
      i_req_data  = data;
      i_req_strob = strob;
      i_req_valid = 1'b1;
      tick();
      i_req_valid = 1'b0;
   endtask

   task automatic waitAxHs(input bit is_write);
      for (int n = 0; n < 40; n++) begin
         if ((!is_write && o_ar_valid && i_ar_ready) || (is_write && o_aw_valid && i_aw_ready)) begin
            tick();
            return;
         end
         tick();
      end
      boundFail(is_write ? "aw_handshake" : "ar_handshake");
   endtask

   task automatic sendR(input logic [63:0] data, input logic [1:0] resp, input logic last);
      i_r_valid = 1'b1;
      i_r_data  = data;
      i_r_resp  = resp;
      i_r_last  = last;
      tick();
      i_r_valid = 1'b0;
      i_r_last  = 1'b0;
   endtask

   task automatic driveW(input int nbeats, input bit alternate);
      int hs = 0;
      int n = 0;
      logic rdy = 1'b1;
      while (hs < nbeats && n < 60) begin
         i_w_ready = rdy;
         if (o_w_valid && i_w_ready) hs++;
         tick();
         n++;
         if (alternate) rdy = ~rdy;
      end
      i_w_ready = 1'b0;
      if (hs < nbeats) boundFail("w_beats");
   endtask

   task automatic finishResp(input string name);
      checkOutput({name, "_resp_latency"}, 256'(o_resp_valid), 256'(1));
      tick();
      checkOutput({name, "_resp_pulse"}, 256'(o_resp_valid), 256'(0));
      checkOutput({name, "_ready_back"}, 256'(o_req_ready), 256'(1));
   endtask

   task automatic cachedRead(input string name, input logic [ADDR_BITS-1:0] addr,
                             input logic [ADDR_BITS-1:0] aligned, input logic [2:0] prot,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3,
                             input int err_beat, input logic [1:0] exp_err);
      exp_ax.push_back({prot, 1'b1, 3'd3, 8'd3, aligned});
      exp_resp.push_back('{line: {d3, d2, d1, d0}, err: exp_err, check_data: 1'b1});
      i_ar_ready = 1'b1;
      applyStimulus(1'b0, 1'b1, 3'd0, prot, addr, '0, '0);
      checkOutput({name, "_ar_latency"}, 256'(o_ar_valid), 256'(1));
      waitAxHs(1'b0);
      sendR(d0, (err_beat == 0) ? 2'b10 : 2'b00, 1'b0);
      sendR(d1, (err_beat == 1) ? 2'b10 : 2'b00, 1'b0);
      sendR(d2, (err_beat == 2) ? 2'b10 : 2'b00, 1'b0);
      sendR(d3, (err_beat == 3) ? 2'b10 : 2'b00, 1'b1);
      finishResp(name);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running, want finished");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int cycles;
      repeat (3) tick();
      i_rst = 1'b0;
      checkOutput("rst_req_ready", 256'(o_req_ready), 256'(1));
      checkOutput("rst_valids", 256'({o_ar_valid, o_aw_valid, o_w_valid, o_resp_valid}), 256'(0));
      checkOutput("rst_err", 256'(o_resp_err), 256'(0));

      // 1: cached read, address line-aligned, beats reassembled in order
      cachedRead("t1", 48'h0000_8000_1234, 48'h0000_8000_1220, 3'b010,
                 64'hD0D0_0000_0000_00D0, 64'hD1D1_1111_1111_11D1,
                 64'hD2D2_2222_2222_22D2, 64'hD3D3_3333_3333_33D3, -1, 2'b00);

      // 2: cached write, alternating w_ready, slave error on B
      exp_ax.push_back({3'b001, 1'b1, 3'd3, 8'd3, 48'h0000_1000_0040});
      exp_w.push_back('{data: 64'hA0A0_0000_0000_00A0, strb: 8'h01, last: 1'b0});
      exp_w.push_back('{data: 64'hA1A1_1111_1111_11A1, strb: 8'hFF, last: 1'b0});
      exp_w.push_back('{data: 64'hA2A2_2222_2222_22A2, strb: 8'h0F, last: 1'b0});
      exp_w.push_back('{data: 64'hA3A3_3333_3333_33A3, strb: 8'hF0, last: 1'b1});
      exp_resp.push_back('{line: '0, err: 2'b10, check_data: 1'b0});
      i_aw_ready = 1'b1;
      applyStimulus(1'b1, 1'b1, 3'd0, 3'b001, 48'h0000_1000_0048,
                    {64'hA3A3_3333_3333_33A3, 64'hA2A2_2222_2222_22A2,
                     64'hA1A1_1111_1111_11A1, 64'hA0A0_0000_0000_00A0}, 32'hF00F_FF01);
      waitAxHs(1'b1);
      driveW(4, 1'b1);
      checkOutput("t2_w_done", 256'(o_w_valid), 256'(0));
      i_b_valid = 1'b1;
      i_b_resp  = 2'b10;
      tick();
      i_b_valid = 1'b0;
      finishResp("t2");

      // 3: uncached 4-byte read at 0x18 lands in slot 3
      exp_ax.push_back({3'b000, 1'b0, 3'd2, 8'd0, 48'h0000_0000_0018});
      exp_resp.push_back('{line: {64'hCAFE_F00D_1234_5678, 192'd0}, err: 2'b00, check_data: 1'b1});
      applyStimulus(1'b0, 1'b0, 3'd2, 3'b000, 48'h0000_0000_0018, '0, '0);
      waitAxHs(1'b0);
      sendR(64'hCAFE_F00D_1234_5678, 2'b00, 1'b1);
      finishResp("t3");

      // 4: SLVERR on the second beat still collects all four beats
      cachedRead("t4", 48'h0000_0000_0040, 48'h0000_0000_0040, 3'b000,
                 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                 64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, 1, 2'b01);

      // 5: watchdog aborts a read whose AR is never accepted
      exp_resp.push_back('{line: '0, err: 2'b01, check_data: 1'b0});
      i_ar_ready = 1'b0;
      applyStimulus(1'b0, 1'b1, 3'd0, 3'b000, 48'h0000_0000_0200, '0, '0);
      cycles = 0;
      while (o_ar_valid && cycles < 100) begin
         cycles++;
         tick();
      end
      checkOutput("t5_ar_cycles", 256'(cycles), 256'(16));
      finishResp("t5");
      i_ar_ready = 1'b1;

      // 6: reset during the second write beat abandons the burst
      exp_ax.push_back({3'b000, 1'b1, 3'd3, 8'd3, 48'h0000_0000_0300});
      exp_w.push_back('{data: 64'h5555_0000_0000_0055, strb: 8'hFF, last: 1'b0});
      applyStimulus(1'b1, 1'b1, 3'd0, 3'b000, 48'h0000_0000_0300,
                    {64'h5858_3333_3333_3358, 64'h5757_2222_2222_2257,
                     64'h5656_1111_1111_1156, 64'h5555_0000_0000_0055}, 32'hFFFF_FFFF);
      waitAxHs(1'b1);
      i_w_ready = 1'b1;
      tick();
      i_w_ready = 1'b0;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      checkOutput("t6_w_valid", 256'(o_w_valid), 256'(0));
      checkOutput("t6_req_ready", 256'(o_req_ready), 256'(1));
      checkOutput("t6_err", 256'(o_resp_err), 256'(0));
      i_b_valid = 1'b1;
      i_b_resp  = 2'b10;
      tick();
      i_b_valid = 1'b0;
      tick();
      checkOutput("t6_late_b_ignored", 256'(o_resp_valid), 256'(0));
      cachedRead("t6_read", 48'h0000_0000_0088, 48'h0000_0000_0080, 3'b000,
                 64'hF0F0_0000_0000_00F0, 64'hF1F1_1111_1111_11F1,
                 64'hF2F2_2222_2222_22F2, 64'hF3F3_3333_3333_33F3, -1, 2'b00);

      tick();
      checkOutput("scoreboard_drained", 256'(exp_resp.size() + exp_ax.size() + exp_w.size()), 256'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
